piso_tx: RTL and testbench

- Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready load handshake.
- Shifts the word out one bit per accepted beat on a serial valid/ready stream.
- Pairs with the team's serial-capture/parallel-register stages as the transmit end of the same bit-serial link.
- Fully synchronous; all state held in flip-flops clocked by clk.

---
 rtl/piso_tx.sv | 110 +++++++++++
 tb/tb_piso_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: one WIDTH-bit word in over valid/ready, one bit out per accepted beat.
// Define PISO_PARITY_EN to append an even-parity beat after the data bits.
module piso_tx #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] parallel_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             serial_out,
   output logic             serial_valid,
   input  logic             serial_ready,
   output logic             serial_last,
   output logic             busy,
   output logic             done
);

   // state | meaning
   // IDLE  | waiting for a word, load_ready high
   // SHIFT | word in flight, one beat offered per cycle

`ifdef PISO_PARITY_EN
   localparam int TOTAL = WIDTH + 1;
`else
   localparam int TOTAL = WIDTH;
`endif
   localparam int SW = TOTAL;
   localparam int CW = $clog2(WIDTH + 2);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] shift_q, shift_d;
   logic [SW-1:0] load_word;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;
   logic          last_beat;

   // Parity sits at the far end of the register so it leaves after the data bits.
   always_comb begin
      load_word = '0;
`ifdef PISO_PARITY_EN
      if (MSB_FIRST)
         load_word = {parallel_in, ^parallel_in};
      else
         load_word = {^parallel_in, parallel_in};
`else
      load_word = parallel_in;
`endif
   end

   assign last_beat = (cnt_q == CW'(TOTAL - 1));

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_valid) begin
               shift_d = load_word;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (serial_ready) begin
               if (MSB_FIRST)
                  shift_d = {shift_q[SW-2:0], 1'b0};
               else
                  shift_d = {1'b0, shift_q[SW-1:1]};
               cnt_d = cnt_q + 1'b1;
               if (last_beat) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign load_ready   = (state_q == IDLE);
   assign busy         = (state_q == SHIFT);
   assign serial_valid = busy;
   assign serial_out   = MSB_FIRST ? shift_q[SW-1] : shift_q[0];
   assign serial_last  = busy && last_beat;
   assign done         = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: an LSB-first and an MSB-first instance share the same stimulus.
// Expected beat sequences follow PISO_PARITY_EN when it is defined for the build.
module tb_piso_tx;

`ifdef PISO_PARITY_EN
   localparam int TOTAL = 5;
`else
   localparam int TOTAL = 4;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] parallel_in = 4'b0000;
   logic       load_valid = 1'b0;
   logic       serial_ready = 1'b0;

   logic load_ready, serial_out, serial_valid, serial_last, busy, done;
   logic load_ready_m, serial_out_m, serial_valid_m, serial_last_m, busy_m, done_m;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut (
      .clk(clk), .reset(reset), .parallel_in(parallel_in), .load_valid(load_valid),
      .load_ready(load_ready), .serial_out(serial_out), .serial_valid(serial_valid),
      .serial_ready(serial_ready), .serial_last(serial_last), .busy(busy), .done(done)
   );

   piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .reset(reset), .parallel_in(parallel_in), .load_valid(load_valid),
      .load_ready(load_ready_m), .serial_out(serial_out_m), .serial_valid(serial_valid_m),
      .serial_ready(serial_ready), .serial_last(serial_last_m), .busy(busy_m), .done(done_m)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one word; returns sampling at beat 0 and scrambles parallel_in afterwards.
   task automatic load(input logic [3:0] w);
      parallel_in = w;
      load_valid  = 1'b1;
      tick();
      load_valid  = 1'b0;
      parallel_in = ~w;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      load_valid = 1'b1;
      serial_ready = 1'b1;
      tick();
      tick();
      total_cnt++; if (serial_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", serial_valid); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else pass_cnt++;
      total_cnt++; if (serial_out !== 1'b0) $display("FAIL rst_out: got %b want 0", serial_out); else pass_cnt++;
      total_cnt++; if (serial_last !== 1'b0) $display("FAIL rst_last: got %b want 0", serial_last); else pass_cnt++;
      total_cnt++; if (load_ready !== 1'b1) $display("FAIL rst_load_ready: got %b want 1", load_ready); else pass_cnt++;
      load_valid = 1'b0;
      serial_ready = 1'b0;
      reset = 1'b1;
      tick();
      total_cnt++; if (load_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", load_ready); else pass_cnt++;
   endtask

   task automatic test_basic();
      logic [4:0] seq = 5'b11011;
      serial_ready = 1'b1;
      load(4'b1011);
      for (int b = 0; b < TOTAL; b++) begin
         total_cnt++; if (serial_valid !== 1'b1) $display("FAIL basic_valid[%0d]: got %b want 1", b, serial_valid); else pass_cnt++;
         total_cnt++; if (serial_out !== seq[b]) $display("FAIL basic_out[%0d]: got %b want %b", b, serial_out, seq[b]); else pass_cnt++;
         total_cnt++; if (serial_last !== (b == TOTAL - 1)) $display("FAIL basic_last[%0d]: got %b want %b", b, serial_last, (b == TOTAL - 1)); else pass_cnt++;
         total_cnt++; if (done !== 1'b0) $display("FAIL basic_early_done[%0d]: got %b want 0", b, done); else pass_cnt++;
         total_cnt++; if (load_ready !== 1'b0) $display("FAIL basic_ready_busy[%0d]: got %b want 0", b, load_ready); else pass_cnt++;
         tick();
      end
      total_cnt++; if (done !== 1'b1) $display("FAIL basic_done: got %b want 1", done); else pass_cnt++;
      total_cnt++; if (serial_valid !== 1'b0) $display("FAIL basic_valid_end: got %b want 0", serial_valid); else pass_cnt++;
      total_cnt++; if (load_ready !== 1'b1) $display("FAIL basic_ready_end: got %b want 1", load_ready); else pass_cnt++;
      tick();
      total_cnt++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", done); else pass_cnt++;
   endtask

   task automatic test_stall();
      logic [4:0] seq = 5'b11011;
      int hold;
      serial_ready = 1'b1;
      load(4'b1011);
      for (int b = 0; b < TOTAL; b++) begin
         hold = (b == 1) ? 2 : 0;
         for (int h = 0; h <= hold; h++) begin
            serial_ready = (h == hold);
            total_cnt++; if (serial_valid !== 1'b1) $display("FAIL stall_valid[%0d.%0d]: got %b want 1", b, h, serial_valid); else pass_cnt++;
            total_cnt++; if (serial_out !== seq[b]) $display("FAIL stall_out[%0d.%0d]: got %b want %b", b, h, serial_out, seq[b]); else pass_cnt++;
            total_cnt++; if (serial_last !== (b == TOTAL - 1)) $display("FAIL stall_last[%0d.%0d]: got %b want %b", b, h, serial_last, (b == TOTAL - 1)); else pass_cnt++;
            total_cnt++; if (done !== 1'b0) $display("FAIL stall_early_done[%0d.%0d]: got %b want 0", b, h, done); else pass_cnt++;
            tick();
         end
      end
      total_cnt++; if (done !== 1'b1) $display("FAIL stall_done: got %b want 1", done); else pass_cnt++;
      tick();
   endtask

   task automatic test_msb_first();
      logic [4:0] seq = 5'b11101;
      serial_ready = 1'b1;
      load(4'b1011);
      for (int b = 0; b < TOTAL; b++) begin
         total_cnt++; if (serial_out_m !== seq[b]) $display("FAIL msb_out[%0d]: got %b want %b", b, serial_out_m, seq[b]); else pass_cnt++;
         total_cnt++; if (serial_last_m !== (b == TOTAL - 1)) $display("FAIL msb_last[%0d]: got %b want %b", b, serial_last_m, (b == TOTAL - 1)); else pass_cnt++;
         tick();
      end
      total_cnt++; if (done_m !== 1'b1) $display("FAIL msb_done: got %b want 1", done_m); else pass_cnt++;
      tick();
   endtask

   task automatic test_load_while_busy();
      logic [4:0] seq = 5'b11011;
      int done_seen = 0;
      serial_ready = 1'b1;
      load(4'b1011);
      for (int b = 0; b < TOTAL; b++) begin
         if (b == 1) begin
            load_valid  = 1'b1;
            parallel_in = 4'b0100;
            total_cnt++; if (load_ready !== 1'b0) $display("FAIL busy_load_ready: got %b want 0", load_ready); else pass_cnt++;
         end
         if (b == 2) load_valid = 1'b0;
         total_cnt++; if (serial_out !== seq[b]) $display("FAIL busy_out[%0d]: got %b want %b", b, serial_out, seq[b]); else pass_cnt++;
         done_seen += int'(done);
         tick();
      end
      for (int c = 0; c < 4; c++) begin
         done_seen += int'(done);
         tick();
      end
      total_cnt++; if (done_seen !== 1) $display("FAIL busy_done_count: got %0d want 1", done_seen); else pass_cnt++;
      total_cnt++; if (serial_valid !== 1'b0) $display("FAIL busy_no_second_word: got %b want 0", serial_valid); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [4:0] seq = 5'b00011;
      serial_ready = 1'b1;
      load(4'b1011);
      repeat (TOTAL) tick();
      total_cnt++; if (load_ready !== 1'b1) $display("FAIL b2b_ready_in_done: got %b want 1", load_ready); else pass_cnt++;
      total_cnt++; if (done !== 1'b1) $display("FAIL b2b_first_done: got %b want 1", done); else pass_cnt++;
      load(4'b0011);
      for (int b = 0; b < TOTAL; b++) begin
         total_cnt++; if (serial_out !== seq[b]) $display("FAIL b2b_out[%0d]: got %b want %b", b, serial_out, seq[b]); else pass_cnt++;
         total_cnt++; if (serial_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", b, serial_valid); else pass_cnt++;
         tick();
      end
      total_cnt++; if (done !== 1'b1) $display("FAIL b2b_second_done: got %b want 1", done); else pass_cnt++;
      tick();
   endtask

   task automatic test_idle_ready();
      serial_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         total_cnt++; if (serial_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL idle_ready[%0d]: got valid=%b busy=%b done=%b want 0/0/0", c, serial_valid, busy, done);
         else pass_cnt++;
         tick();
      end
   endtask

   task automatic test_mid_reset();
      serial_ready = 1'b1;
      load(4'b1111);
      tick();
      tick();
      total_cnt++; if (serial_valid !== 1'b1) $display("FAIL midrst_pre_valid: got %b want 1", serial_valid); else pass_cnt++;
      reset = 1'b0;
      tick();
      total_cnt++; if (serial_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", serial_valid); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (serial_out !== 1'b0) $display("FAIL midrst_out: got %b want 0", serial_out); else pass_cnt++;
      load_valid = 1'b1;
      parallel_in = 4'b1010;
      tick();
      total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_load_ignored: got %b want 0", busy); else pass_cnt++;
      load_valid = 1'b0;
      reset = 1'b1;
      tick();
      total_cnt++; if (load_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", load_ready); else pass_cnt++;
      for (int c = 0; c < TOTAL + 2; c++) begin
         total_cnt++; if (done !== 1'b0 || serial_valid !== 1'b0)
            $display("FAIL midrst_quiet[%0d]: got done=%b valid=%b want 0/0", c, done, serial_valid);
         else pass_cnt++;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_msb_first();
      test_load_while_busy();
      test_back_to_back();
      test_idle_ready();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
